// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a single-outstanding refill controller.
// Hits return data combinationally; misses stall fetch while a line is refilled from memory.
module icache_fill_ctrl #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 64,
  parameter int NUM_LINES = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid_in,
  input  logic              ic_read_req_in,
  input  logic [ADDR_W-1:0] ic_addr_in,
  output logic [DATA_W-1:0] ic_data_out,
  output logic              cache_stall_out,
  input  logic              inv_all_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_ack_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [CNT_W-1:0]  hit_cnt_out,
  output logic [CNT_W-1:0]  miss_cnt_out
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILL   = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [NUM_LINES];
  logic [DATA_W-1:0]  data_mem [NUM_LINES];
  logic [ADDR_W-1:0]  miss_addr;
  logic [DATA_W-1:0]  fill_buf;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   fill_idx;
  logic               hit;
  logic               start_refill;

  assign idx      = ic_addr_in[IDX_W-1:0];
  assign tag      = ic_addr_in[ADDR_W-1:IDX_W];
  assign fill_idx = miss_addr[IDX_W-1:0];
  assign hit      = valid[idx] && (tag_mem[idx] == tag);

  // Stall deliberately ignores ic_read_req_in: fetch gates its request with stall.
  assign ic_data_out     = data_mem[idx];
  assign cache_stall_out = (state != IDLE) | (fetch_valid_in & ~hit);
  assign mem_req_out     = (state == REFILL);
  assign mem_addr_out    = miss_addr;
  assign hit_cnt_out     = hit_cnt;
  assign miss_cnt_out    = miss_cnt;
  assign start_refill    = (state == IDLE) && (next_state == REFILL);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fetch_valid_in && !hit) next_state = REFILL;
      REFILL:  if (mem_ack_in) next_state = FILL;
      FILL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state <= next_state;
      if (start_refill) begin
        miss_addr <= ic_addr_in;
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end
      if ((state == IDLE) && ic_read_req_in && hit && (hit_cnt != '1))
        hit_cnt <= hit_cnt + CNT_W'(1);
      // Invalidate-all wins over a same-cycle install.
      if (inv_all_in)
        valid <= '0;
      else if (state == FILL)
        valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state == REFILL) && mem_ack_in)
      fill_buf <= mem_data_in;
    if (!rst && (state == FILL) && !inv_all_in) begin
      tag_mem[fill_idx]  <= miss_addr[ADDR_W-1:IDX_W];
      data_mem[fill_idx] <= fill_buf;
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed testbench for icache_fill_ctrl: miss/refill timing, hits, conflicts,
// invalidation, reset during refill and counter saturation.
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        read_req;
  logic [29:0] addr;
  logic [63:0] data;
  logic        stall;
  logic        inv_all;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_data;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  icache_fill_ctrl #(.ADDR_W(30), .DATA_W(64), .NUM_LINES(16), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid_in (fetch_valid),
    .ic_read_req_in (read_req),
    .ic_addr_in     (addr),
    .ic_data_out    (data),
    .cache_stall_out(stall),
    .inv_all_in     (inv_all),
    .mem_req_out    (mem_req),
    .mem_addr_out   (mem_addr),
    .mem_ack_in     (mem_ack),
    .mem_data_in    (mem_data),
    .hit_cnt_out    (hit_cnt),
    .miss_cnt_out   (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_valid = 1'b0; read_req = 1'b0; addr = '0;
    inv_all = 1'b0; mem_ack = 1'b0; mem_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Miss on a, with refill_cycles cycles in REFILL (ack in the last one).
  // Ends mid-cycle in the cycle after FILL without advancing the clock.
  task automatic do_miss(input logic [29:0] a, input logic [63:0] d, input int refill_cycles,
                         input bit inv_in_fill, input logic [15:0] exp_miss);
    fetch_valid = 1'b1; addr = a; read_req = 1'b0; mem_ack = 1'b0; inv_all = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL miss_cycle addr=%h stall=%b req=%b expected stall=1 req=0", a, stall, mem_req);
    end
    tick();
    for (int i = 1; i <= refill_cycles; i++) begin
      if (i == refill_cycles) begin mem_ack = 1'b1; mem_data = d; end
      #1;
      checks++;
      if (stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== a) begin
        errors++;
        $display("[TB] FAIL refill_cycle%0d stall=%b req=%b mem_addr=%h expected 1 1 %h",
                 i, stall, mem_req, mem_addr, a);
      end
      tick();
    end
    mem_ack = 1'b0; mem_data = '0;
    if (inv_in_fill) inv_all = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_cycle stall=%b req=%b expected stall=1 req=0", stall, mem_req);
    end
    tick();
    inv_all = 1'b0;
    #1;
    checks++;
    if (miss_cnt !== exp_miss) begin
      errors++;
      $display("[TB] FAIL miss_cnt got %0d expected %0d", miss_cnt, exp_miss);
    end
    checks++;
    if (inv_in_fill) begin
      if (stall !== 1'b1) begin
        errors++;
        $display("[TB] FAIL after_inv_fill stall=%b expected 1", stall);
      end
    end else if (stall !== 1'b0 || data !== d) begin
      errors++;
      $display("[TB] FAIL after_fill stall=%b data=%h expected stall=0 data=%h", stall, data, d);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_state stall=%b req=%b hit=%0d miss=%0d expected 0 0 0 0",
               stall, mem_req, hit_cnt, miss_cnt);
    end
    fetch_valid = 1'b1; addr = 30'h0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_invalid stall=%b expected 1", stall);
    end
    fetch_valid = 1'b0;
  endtask

  task automatic test_miss_latency();
    do_miss(30'h05, 64'h0000_0012_3456_789A, 4, 1'b0, 16'd1);
  endtask

  task automatic test_hits();
    read_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || data !== 64'h0000_0012_3456_789A) begin
        errors++;
        $display("[TB] FAIL hit%0d stall=%b req=%b data=%h expected 0 0 0000_0012_3456_789A",
                 i, stall, mem_req, data);
      end
      tick();
    end
    read_req = 1'b0;
    #1;
    checks++;
    if (hit_cnt !== 16'd4 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hit_cnt got %0d req=%b expected 4 req=0", hit_cnt, mem_req);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    do_miss(30'h00, 64'h0000_0011_1111_1111, 2, 1'b0, 16'd1);
    tick();
    do_miss(30'h10, 64'h0000_0022_2222_2222, 1, 1'b0, 16'd2);
    tick();
    do_miss(30'h00, 64'h0000_0033_3333_3333, 3, 1'b0, 16'd3);
  endtask

  task automatic test_inv_in_fill();
    tick();
    do_miss(30'h07, 64'h0000_0077_0000_0007, 2, 1'b1, 16'd4);
    do_miss(30'h07, 64'h0000_0077_0000_0017, 2, 1'b0, 16'd5);
    addr = 30'h00;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inv_cleared_other stall=%b expected 1", stall);
    end
  endtask

  task automatic test_reset_in_refill();
    do_reset();
    fetch_valid = 1'b1; addr = 30'h05;
    tick();
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h05) begin
      errors++;
      $display("[TB] FAIL pre_reset_refill req=%b mem_addr=%h expected 1 05", mem_req, mem_addr);
    end
    rst = 1'b1; fetch_valid = 1'b0;
    tick();
    rst = 1'b0; mem_ack = 1'b1; mem_data = 64'h0000_00DE_AD00_BEEF;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL after_reset req=%b stall=%b hit=%0d miss=%0d expected 0 0 0 0",
               mem_req, stall, hit_cnt, miss_cnt);
    end
    tick();
    mem_ack = 1'b0; mem_data = '0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_ignored req=%b stall=%b expected 0 0", mem_req, stall);
    end
    do_miss(30'h05, 64'h0000_0055_5555_5555, 1, 1'b0, 16'd1);
  endtask

  task automatic test_saturation();
    do_reset();
    do_miss(30'h03, 64'h0000_0033_0000_0003, 1, 1'b0, 16'd1);
    read_req = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    read_req = 1'b0;
    #1;
    checks++;
    if (hit_cnt !== 16'hFFFE) begin
      errors++;
      $display("[TB] FAIL hit_cnt_pre_sat got %h expected FFFE", hit_cnt);
    end
    read_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    read_req = 1'b0;
    #1;
    checks++;
    if (hit_cnt !== 16'hFFFF || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hit_cnt_sat got %h stall=%b expected FFFF 0", hit_cnt, stall);
    end
    fetch_valid = 1'b0; addr = 30'h2A;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_fetch_valid stall=%b req=%b expected 0 0", stall, mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b0 || miss_cnt !== 16'd1 || hit_cnt !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL no_fetch_valid_next req=%b miss=%0d hit=%h expected 0 1 FFFF",
               mem_req, miss_cnt, hit_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_miss_latency();
    test_hits();
    test_conflict();
    test_inv_in_fill();
    test_reset_in_refill();
    test_saturation();
    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
